// File: rtl/tanh_pkg.sv
// Shared widths, sample/data types and saturation bounds for the tanh interpolator.
// Rounding mode is selected in tanh_lerp via TANH_INTERP_ROUND_EN.
package tanh_pkg;

  localparam int ADDR_W = 4;
  localparam int FRAC_W = 4;
  localparam int DATA_W = 8;
  localparam int X_W    = ADDR_W + FRAC_W;
  localparam int PROD_W = DATA_W + FRAC_W + 2;

  // Address occupies the upper bits of the sample, fraction the lower bits.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [FRAC_W-1:0] frac;
  } tanh_sample_t;

  typedef logic signed [DATA_W-1:0] tanh_data_t;

  localparam int SAT_MAX = 2 ** (DATA_W - 1) - 1;
  localparam int SAT_MIN = -(2 ** (DATA_W - 1));

endpackage

// File: rtl/tanh_lerp.sv
// Combinational linear interpolation between two signed LUT entries, saturated to DATA_W.
// Define TANH_INTERP_ROUND_EN for round-half-up; default build floors the scaled product.
module tanh_lerp
  import tanh_pkg::*;
(
  input  logic [DATA_W-1:0] base_i,
  input  logic [DATA_W-1:0] next_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic [DATA_W-1:0] y_o
);

  localparam int SUM_W = PROD_W + 1;
  localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(SAT_MAX);
  localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(SAT_MIN);

  logic signed [DATA_W:0]   diff_s;
  logic signed [PROD_W-1:0] diff_ext;
  logic signed [PROD_W-1:0] frac_ext;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [PROD_W-1:0] prod_adj;
  logic signed [PROD_W-1:0] shift_s;
  logic signed [SUM_W-1:0]  sum_s;

  assign diff_s   = {next_i[DATA_W-1], next_i} - {base_i[DATA_W-1], base_i};
  assign diff_ext = {{(PROD_W-DATA_W-1){diff_s[DATA_W]}}, diff_s};
  // Fraction is unsigned: zero-extend so the product stays signed on diff alone.
  assign frac_ext = {{(PROD_W-FRAC_W){1'b0}}, frac_i};
  assign prod_s   = diff_ext * frac_ext;

`ifdef TANH_INTERP_ROUND_EN
  localparam logic signed [PROD_W-1:0] HALF_LSB = PROD_W'(2 ** (FRAC_W - 1));
  assign prod_adj = prod_s + HALF_LSB;
`else
  assign prod_adj = prod_s;
`endif

  assign shift_s = prod_adj >>> FRAC_W;
  assign sum_s   = {{(SUM_W-DATA_W){base_i[DATA_W-1]}}, base_i} +
                   {shift_s[PROD_W-1], shift_s};

  always_comb begin
    y_o = sum_s[DATA_W-1:0];
    if (sum_s > SUM_MAX) begin
      y_o = DATA_W'(SAT_MAX);
    end else if (sum_s < SUM_MIN) begin
      y_o = DATA_W'(SAT_MIN);
    end
  end

endmodule

// File: rtl/tanh_interp.sv
// Two-stage valid/ready pipeline: S1 holds the sample and addresses the external LUT,
// S2 registers the interpolated tanh. Rounding selected by TANH_INTERP_ROUND_EN (see tanh_lerp).
module tanh_interp
  import tanh_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [X_W-1:0]    in_x,
  output logic [ADDR_W-1:0] lut_address,
  input  logic [DATA_W-1:0] lut_base,
  input  logic [DATA_W-1:0] lut_next,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_y
);

  tanh_sample_t s1_x_q, s1_x_d;
  logic         s1_valid_q, s1_valid_d;
  logic         out_valid_q, out_valid_d;
  tanh_data_t   out_y_q, out_y_d;
  tanh_data_t   lerp_y;
  logic         stall;
  logic         accept;

  assign stall       = out_valid_q && !out_ready;
  // An empty S1 may still fill while S2 is stalled.
  assign in_ready    = !(s1_valid_q && stall);
  assign accept      = in_valid && in_ready;
  assign lut_address = s1_x_q.addr;

  tanh_lerp u_lerp (
    .base_i (lut_base),
    .next_i (lut_next),
    .frac_i (s1_x_q.frac),
    .y_o    (lerp_y)
  );

  always_comb begin
    s1_x_d      = s1_x_q;
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    if (accept) begin
      s1_x_d     = tanh_sample_t'(in_x);
      s1_valid_d = 1'b1;
    end else if (!stall) begin
      s1_valid_d = 1'b0;
    end
    if (!stall) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_y_d = lerp_y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_x_q      <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
    end else begin
      s1_x_q      <= s1_x_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;

endmodule
